// File: rtl/ovi_sb_tracker_pkg.sv
// Shared types for the OVI scoreboard tracker: entry lifecycle states,
// sb_id width and the per-entry record kept in the ring.
package ovi_pkg;

    localparam int OVI_SBID_WIDTH = 5;
    localparam int OVI_REG_WIDTH  = 5;

    typedef enum logic [1:0] {
        SB_FREE       = 2'd0,
        SB_ISSUED     = 2'd1,
        SB_DISPATCHED = 2'd2,
        SB_DONE       = 2'd3
    } sb_state_e;

    typedef struct packed {
        sb_state_e                state;
        logic                     wb;
        logic [OVI_REG_WIDTH-1:0] dst;
    } sb_entry_t;

endpackage

// File: rtl/ovi_sb_tracker_if.sv
// Bundle of issue, dispatch, completion and writeback signals between the
// core-side driver (master) and the scoreboard tracker (slave).
interface ovi_sb_tracker_if #(
    parameter int NUM_SB = 8,
    parameter int DATA_W = 64
);
    import ovi_pkg::*;

    localparam int CNT_W = $clog2(NUM_SB + 1);

    logic                      iss_valid_i;
    logic                      iss_wb_i;
    logic [OVI_REG_WIDTH-1:0]  iss_dst_i;
    logic                      iss_ready_o;
    logic [OVI_SBID_WIDTH-1:0] iss_sb_id_o;

    logic                      commit_i;
    logic                      kill_i;
    logic [OVI_SBID_WIDTH-1:0] disp_sb_id_o;
    logic                      disp_next_senior_o;
    logic                      disp_kill_o;

    logic                      cmpl_valid_i;
    logic [OVI_SBID_WIDTH-1:0] cmpl_sb_id_i;
    logic [DATA_W-1:0]         cmpl_dest_reg_i;

    logic                      wb_valid_o;
    logic [OVI_REG_WIDTH-1:0]  wb_dst_o;
    logic [DATA_W-1:0]         wb_data_o;

    logic [CNT_W-1:0]          count_o;
    logic                      err_o;

    modport master (
        output iss_valid_i, iss_wb_i, iss_dst_i,
        output commit_i, kill_i,
        output cmpl_valid_i, cmpl_sb_id_i, cmpl_dest_reg_i,
        input  iss_ready_o, iss_sb_id_o,
        input  disp_sb_id_o, disp_next_senior_o, disp_kill_o,
        input  wb_valid_o, wb_dst_o, wb_data_o,
        input  count_o, err_o
    );

    modport slave (
        input  iss_valid_i, iss_wb_i, iss_dst_i,
        input  commit_i, kill_i,
        input  cmpl_valid_i, cmpl_sb_id_i, cmpl_dest_reg_i,
        output iss_ready_o, iss_sb_id_o,
        output disp_sb_id_o, disp_next_senior_o, disp_kill_o,
        output wb_valid_o, wb_dst_o, wb_data_o,
        output count_o, err_o
    );

endinterface

// File: rtl/ovi_sb_tracker_wrap_ctr.sv
// Modulo-MODULO pointer counter used for the head, tail and dispatch
// pointers of the scoreboard ring.
module ovi_wrap_ctr #(
    parameter int MODULO = 8
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      inc_i,
    output logic [$clog2(MODULO)-1:0] value_o
);

    localparam int W = $clog2(MODULO);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Advance by one on request, wrapping from MODULO-1 back to zero.
    always_comb begin
        value_d = value_q;
        if (inc_i) begin
            value_d = (value_q == W'(MODULO - 1)) ? '0 : value_q + W'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/ovi_sb_tracker.sv
// Scoreboard tracker for outstanding OVI vector instructions: allocates
// sb_ids in a ring, sequences commit/kill to the VPU in order, turns VPU
// completions into scalar writebacks and retires entries in order.
module ovi_sb_tracker
    import ovi_pkg::*;
#(
    parameter int NUM_SB = 8,
    parameter int DATA_W = 64
) (
    input logic              clk,
    input logic              rst_l,
    ovi_sb_tracker_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_SB);
    localparam int CNT_W = $clog2(NUM_SB + 1);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] disp_ptr;
    logic             head_inc;
    logic             tail_inc;
    logic             disp_inc;

    sb_entry_t entries_q [NUM_SB];
    sb_entry_t entries_d [NUM_SB];

    logic [CNT_W-1:0]          count_q,       count_d;
    logic                      err_q,         err_d;
    logic                      next_senior_q, next_senior_d;
    logic                      disp_kill_q,   disp_kill_d;
    logic [OVI_SBID_WIDTH-1:0] disp_id_q,     disp_id_d;
    logic                      wb_valid_q,    wb_valid_d;
    logic [OVI_REG_WIDTH-1:0]  wb_dst_q,      wb_dst_d;
    logic [DATA_W-1:0]         wb_data_q,     wb_data_d;

    logic             iss_ready;
    logic             iss_fire;
    logic             disp_req;
    logic             disp_ok;
    logic             cmpl_in_range;
    logic             cmpl_ok;
    logic [PTR_W-1:0] cmpl_idx;
    logic             retire;

    ovi_wrap_ctr #(.MODULO(NUM_SB)) u_head_ctr (
        .clk     (clk),
        .rst_l   (rst_l),
        .inc_i   (head_inc),
        .value_o (head_ptr)
    );

    ovi_wrap_ctr #(.MODULO(NUM_SB)) u_tail_ctr (
        .clk     (clk),
        .rst_l   (rst_l),
        .inc_i   (tail_inc),
        .value_o (tail_ptr)
    );

    ovi_wrap_ctr #(.MODULO(NUM_SB)) u_disp_ctr (
        .clk     (clk),
        .rst_l   (rst_l),
        .inc_i   (disp_inc),
        .value_o (disp_ptr)
    );

    // Every decision reads registered entry state only, so issue, dispatch,
    // completion and retirement always target different entries in a cycle.
    always_comb begin
        iss_ready     = (count_q < CNT_W'(NUM_SB));
        iss_fire      = bus.iss_valid_i && iss_ready;
        retire        = (entries_q[head_ptr].state == SB_DONE);
        disp_req      = bus.commit_i || bus.kill_i;
        disp_ok       = disp_req && (entries_q[disp_ptr].state == SB_ISSUED);
        cmpl_in_range = (32'(bus.cmpl_sb_id_i) < 32'(NUM_SB));
        cmpl_idx      = bus.cmpl_sb_id_i[PTR_W-1:0];
        cmpl_ok       = bus.cmpl_valid_i && cmpl_in_range &&
                        (entries_q[cmpl_idx].state == SB_DISPATCHED);

        entries_d     = entries_q;
        next_senior_d = 1'b0;
        disp_kill_d   = 1'b0;
        disp_id_d     = disp_id_q;
        wb_valid_d    = 1'b0;
        wb_dst_d      = wb_dst_q;
        wb_data_d     = wb_data_q;

        if (retire) begin
            entries_d[head_ptr].state = SB_FREE;
        end

        if (iss_fire) begin
            entries_d[tail_ptr].state = SB_ISSUED;
            entries_d[tail_ptr].wb    = bus.iss_wb_i;
            entries_d[tail_ptr].dst   = bus.iss_dst_i;
        end

        if (disp_ok) begin
            disp_id_d = OVI_SBID_WIDTH'(disp_ptr);
            if (bus.kill_i) begin
                entries_d[disp_ptr].state = SB_DONE;
                disp_kill_d               = 1'b1;
            end else begin
                entries_d[disp_ptr].state = SB_DISPATCHED;
                next_senior_d             = 1'b1;
            end
        end

        if (cmpl_ok) begin
            entries_d[cmpl_idx].state = SB_DONE;
            if (entries_q[cmpl_idx].wb) begin
                wb_valid_d = 1'b1;
                wb_dst_d   = entries_q[cmpl_idx].dst;
                wb_data_d  = bus.cmpl_dest_reg_i;
            end
        end

        err_d = err_q ||
                (bus.iss_valid_i && !iss_ready) ||
                (disp_req && !disp_ok) ||
                (bus.cmpl_valid_i && !cmpl_ok);

        count_d  = count_q + CNT_W'(iss_fire) - CNT_W'(retire);
        head_inc = retire;
        tail_inc = iss_fire;
        disp_inc = disp_ok;
    end

    // Entry ring and registered outputs; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_SB; i++) begin
                entries_q[i] <= '{state: SB_FREE, wb: 1'b0, dst: '0};
            end
            count_q       <= '0;
            err_q         <= 1'b0;
            next_senior_q <= 1'b0;
            disp_kill_q   <= 1'b0;
            disp_id_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_dst_q      <= '0;
            wb_data_q     <= '0;
        end else begin
            entries_q     <= entries_d;
            count_q       <= count_d;
            err_q         <= err_d;
            next_senior_q <= next_senior_d;
            disp_kill_q   <= disp_kill_d;
            disp_id_q     <= disp_id_d;
            wb_valid_q    <= wb_valid_d;
            wb_dst_q      <= wb_dst_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign bus.iss_ready_o        = iss_ready;
    assign bus.iss_sb_id_o        = OVI_SBID_WIDTH'(tail_ptr);
    assign bus.disp_sb_id_o       = disp_id_q;
    assign bus.disp_next_senior_o = next_senior_q;
    assign bus.disp_kill_o        = disp_kill_q;
    assign bus.wb_valid_o         = wb_valid_q;
    assign bus.wb_dst_o           = wb_dst_q;
    assign bus.wb_data_o          = wb_data_q;
    assign bus.count_o            = count_q;
    assign bus.err_o              = err_q;

endmodule

// File: tb/tb_ovi_sb_tracker.sv
// Self-checking bench for ovi_sb_tracker: directed scenarios plus a
// randomized run checked against a program-order queue model.
module tb_ovi_sb_tracker;

    localparam int NUM_SB = 8;
    localparam int DATA_W = 64;
    localparam int CNT_W  = $clog2(NUM_SB + 1);

    localparam int PH_ISSUED = 1;
    localparam int PH_DISP   = 2;
    localparam int PH_DONE   = 3;

    typedef struct {
        int id;
        bit wb;
        int dst;
        int phase;
    } ent_t;

    logic clk;
    logic rst_l;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight instructions in program order.
    ent_t              q[$];
    int                m_total;
    bit                m_err;
    bit                m_wbv;
    int                m_wbdst;
    logic [DATA_W-1:0] m_wbdata;
    bit                m_ns;
    bit                m_kill;
    int                m_dispid;

    ovi_sb_tracker_if #(.NUM_SB(NUM_SB), .DATA_W(DATA_W)) bus ();

    ovi_sb_tracker #(.NUM_SB(NUM_SB), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_total  = 0;
        m_err    = 0;
        m_wbv    = 0;
        m_wbdst  = 0;
        m_wbdata = '0;
        m_ns     = 0;
        m_kill   = 0;
        m_dispid = 0;
    endtask

    // One clock edge of the model, driven from the rules for a cycle.
    task automatic model_step(input bit iv, input bit wb, input int dst,
                              input bit cm, input bit kl, input bit cv,
                              input int cid, input logic [DATA_W-1:0] cd);
        bit ret;
        bit rdy;
        int di;
        int ci;
        ret    = (q.size() > 0) && (q[0].phase == PH_DONE);
        rdy    = (q.size() < NUM_SB);
        m_ns   = 0;
        m_kill = 0;
        m_wbv  = 0;
        di = -1;
        ci = -1;
        foreach (q[i]) begin
            if (di < 0 && q[i].phase == PH_ISSUED) di = i;
            if (q[i].id == cid && q[i].phase == PH_DISP) ci = i;
        end
        if (cv) begin
            if (ci < 0) m_err = 1;
            else begin
                q[ci].phase = PH_DONE;
                if (q[ci].wb) begin
                    m_wbv    = 1;
                    m_wbdst  = q[ci].dst;
                    m_wbdata = cd;
                end
            end
        end
        if (cm || kl) begin
            if (di < 0) m_err = 1;
            else begin
                m_dispid = q[di].id;
                if (kl) begin
                    q[di].phase = PH_DONE;
                    m_kill = 1;
                end else begin
                    q[di].phase = PH_DISP;
                    m_ns = 1;
                end
            end
        end
        if (ret) void'(q.pop_front());
        if (iv) begin
            if (rdy) begin
                q.push_back('{id: m_total % NUM_SB, wb: wb, dst: dst, phase: PH_ISSUED});
                m_total++;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic cycle(input bit iv, input bit wb, input int dst,
                         input bit cm, input bit kl, input bit cv,
                         input int cid, input logic [DATA_W-1:0] cd);
        bus.iss_valid_i     = iv;
        bus.iss_wb_i        = wb;
        bus.iss_dst_i       = 5'(dst);
        bus.commit_i        = cm;
        bus.kill_i          = kl;
        bus.cmpl_valid_i    = cv;
        bus.cmpl_sb_id_i    = 5'(cid);
        bus.cmpl_dest_reg_i = cd;
        @(posedge clk);
        model_step(iv, wb, dst, cm, kl, cv, cid, cd);
        #1;
        bus.iss_valid_i  = 1'b0;
        bus.commit_i     = 1'b0;
        bus.kill_i       = 1'b0;
        bus.cmpl_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        bus.iss_valid_i     = 1'b0;
        bus.iss_wb_i        = 1'b0;
        bus.iss_dst_i       = '0;
        bus.commit_i        = 1'b0;
        bus.kill_i          = 1'b0;
        bus.cmpl_valid_i    = 1'b0;
        bus.cmpl_sb_id_i    = '0;
        bus.cmpl_dest_reg_i = '0;
        rst_l = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.count_o !== '0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count_o);
        end
        checks++;
        if (bus.iss_ready_o !== 1'b1 || bus.iss_sb_id_o !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_ready_id: got %b/%0d expected 1/0", bus.iss_ready_o, bus.iss_sb_id_o);
        end
        checks++;
        if ({bus.err_o, bus.wb_valid_o, bus.disp_next_senior_o, bus.disp_kill_o} !== 4'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b%b%b%b expected 0000",
                               bus.err_o, bus.wb_valid_o, bus.disp_next_senior_o, bus.disp_kill_o);
        end
    endtask

    task automatic test_issue_three();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.iss_sb_id_o !== 5'(i)) begin
                errors++; $display("[TB] FAIL issue_id: got %0d expected %0d", bus.iss_sb_id_o, i);
            end
            cycle(1, 1, 5 + i, 0, 0, 0, 0, '0);
        end
        checks++;
        if (bus.count_o !== CNT_W'(3) || bus.iss_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL issue_count: got %0d expected 3", bus.count_o);
        end
    endtask

    task automatic test_out_of_order_complete();
        logic [DATA_W-1:0] data [3];
        int order [3];
        data[0] = 64'hAAAA_0000_1111_2222;
        data[1] = 64'hBBBB_3333_4444_5555;
        data[2] = 64'hCCCC_6666_7777_8888;
        order[0] = 2; order[1] = 0; order[2] = 1;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 0, 0, 0, '0);
            checks++;
            if (bus.disp_next_senior_o !== 1'b1 || bus.disp_kill_o !== 1'b0 || bus.disp_sb_id_o !== 5'(k)) begin
                errors++; $display("[TB] FAIL commit_pulse: got ns=%b kill=%b id=%0d expected 1/0/%0d",
                                   bus.disp_next_senior_o, bus.disp_kill_o, bus.disp_sb_id_o, k);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 1, order[k], data[k]);
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_dst_o !== 5'(5 + order[k]) || bus.wb_data_o !== data[k]) begin
                errors++; $display("[TB] FAIL ooo_wb: got v=%b dst=%0d data=%h expected 1/%0d/%h",
                                   bus.wb_valid_o, bus.wb_dst_o, bus.wb_data_o, 5 + order[k], data[k]);
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, '0);
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL wb_single_pulse: got %b expected 0", bus.wb_valid_o);
        end
        idle(2);
        checks++;
        if (bus.count_o !== '0 || bus.err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL ooo_retire: got count=%0d err=%b expected 0/0", bus.count_o, bus.err_o);
        end
    endtask

    task automatic test_kill_wins();
        do_reset();
        cycle(1, 1, 9, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 1, 1, 0, 0, '0);
        checks++;
        if (bus.disp_kill_o !== 1'b1 || bus.disp_next_senior_o !== 1'b0 || bus.disp_sb_id_o !== 5'd0) begin
            errors++; $display("[TB] FAIL kill_wins: got kill=%b ns=%b id=%0d expected 1/0/0",
                               bus.disp_kill_o, bus.disp_next_senior_o, bus.disp_sb_id_o);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, '0);
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.count_o !== '0 || bus.err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL kill_retire: got wb=%b count=%0d err=%b expected 0/0/0",
                               bus.wb_valid_o, bus.count_o, bus.err_o);
        end
    endtask

    task automatic test_cmpl_to_free();
        do_reset();
        cycle(0, 0, 0, 0, 0, 1, 4, 64'h1234);
        checks++;
        if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL cmpl_free: got err=%b wb=%b expected 1/0", bus.err_o, bus.wb_valid_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < NUM_SB; i++) cycle(1, 0, i, 0, 0, 0, 0, '0);
        checks++;
        if (bus.iss_ready_o !== 1'b0 || bus.count_o !== CNT_W'(NUM_SB) || bus.err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL fill_full: got ready=%b count=%0d err=%b expected 0/%0d/0",
                               bus.iss_ready_o, bus.count_o, bus.err_o, NUM_SB);
        end
        cycle(1, 0, 3, 0, 0, 0, 0, '0);
        checks++;
        if (bus.err_o !== 1'b1 || bus.count_o !== CNT_W'(NUM_SB)) begin
            errors++; $display("[TB] FAIL overflow: got err=%b count=%0d expected 1/%0d",
                               bus.err_o, bus.count_o, NUM_SB);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.iss_sb_id_o !== 5'(i % NUM_SB)) begin
                errors++; $display("[TB] FAIL wrap_id: got %0d expected %0d", bus.iss_sb_id_o, i % NUM_SB);
            end
            cycle(1, 0, i, 0, 0, 0, 0, '0);
            cycle(0, 0, 0, 0, 1, 0, 0, '0);
        end
        idle(2);
        checks++;
        if (bus.count_o !== '0 || bus.err_o !== 1'b0 || bus.iss_sb_id_o !== 5'd2) begin
            errors++; $display("[TB] FAIL wrap_end: got count=%0d err=%b id=%0d expected 0/0/2",
                               bus.count_o, bus.err_o, bus.iss_sb_id_o);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cycle(1, 1, 3, 0, 0, 0, 0, '0);
        cycle(1, 1, 4, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 1, 0, 0, 0, '0);
        bus.cmpl_valid_i    = 1'b1;
        bus.cmpl_sb_id_i    = 5'd0;
        bus.cmpl_dest_reg_i = 64'hDEAD;
        #2;
        rst_l = 1'b0;
        #1;
        checks++;
        if (bus.count_o !== '0 || bus.disp_next_senior_o !== 1'b0 || bus.iss_sb_id_o !== 5'd0) begin
            errors++; $display("[TB] FAIL midreset_async: got count=%0d ns=%b id=%0d expected 0/0/0",
                               bus.count_o, bus.disp_next_senior_o, bus.iss_sb_id_o);
        end
        @(posedge clk);
        #1;
        bus.cmpl_valid_i = 1'b0;
        rst_l = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, '0);
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.count_o !== '0 || bus.err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_after: got wb=%b count=%0d err=%b expected 0/0/0",
                               bus.wb_valid_o, bus.count_o, bus.err_o);
        end
    endtask

    // legal=1 keeps stimulus within protocol; legal=0 injects violations.
    task automatic test_random(input bit legal, input int n);
        bit iv, wb, cm, kl, cv;
        int dst, cid;
        bit has_issued;
        int dl[$];
        logic [DATA_W-1:0] cd;
        do_reset();
        for (int c = 0; c < n; c++) begin
            dl.delete();
            has_issued = 0;
            foreach (q[i]) begin
                if (q[i].phase == PH_DISP) dl.push_back(q[i].id);
                if (q[i].phase == PH_ISSUED) has_issued = 1;
            end
            iv  = ($urandom_range(0, 99) < 55);
            wb  = $urandom_range(0, 1);
            dst = $urandom_range(0, 31);
            cm  = ($urandom_range(0, 99) < 40);
            kl  = ($urandom_range(0, 99) < 10);
            cv  = (dl.size() > 0) && ($urandom_range(0, 99) < 50);
            cid = cv ? dl[$urandom_range(0, dl.size() - 1)] : 0;
            cd  = {$urandom, $urandom};
            if (legal) begin
                if (q.size() >= NUM_SB) iv = 0;
                if (!has_issued) begin cm = 0; kl = 0; end
            end else if ($urandom_range(0, 99) < 3) begin
                cv  = 1;
                cid = $urandom_range(0, 31);
            end
            cycle(iv, wb, dst, cm, kl, cv, cid, cd);
            checks++;
            if (bus.count_o !== CNT_W'(q.size()) || bus.iss_ready_o !== (q.size() < NUM_SB)) begin
                errors++; $display("[TB] FAIL rnd_count: cyc %0d got %0d/%b expected %0d", c, bus.count_o, bus.iss_ready_o, q.size());
            end
            checks++;
            if (bus.iss_sb_id_o !== 5'(m_total % NUM_SB) || bus.err_o !== m_err) begin
                errors++; $display("[TB] FAIL rnd_id_err: cyc %0d got id=%0d err=%b expected %0d/%b",
                                   c, bus.iss_sb_id_o, bus.err_o, m_total % NUM_SB, m_err);
            end
            checks++;
            if (bus.disp_next_senior_o !== m_ns || bus.disp_kill_o !== m_kill ||
                ((m_ns || m_kill) && bus.disp_sb_id_o !== 5'(m_dispid))) begin
                errors++; $display("[TB] FAIL rnd_disp: cyc %0d got ns=%b kill=%b id=%0d expected %b/%b/%0d",
                                   c, bus.disp_next_senior_o, bus.disp_kill_o, bus.disp_sb_id_o, m_ns, m_kill, m_dispid);
            end
            checks++;
            if (bus.wb_valid_o !== m_wbv ||
                (m_wbv && (bus.wb_dst_o !== 5'(m_wbdst) || bus.wb_data_o !== m_wbdata))) begin
                errors++; $display("[TB] FAIL rnd_wb: cyc %0d got v=%b dst=%0d data=%h expected %b/%0d/%h",
                                   c, bus.wb_valid_o, bus.wb_dst_o, bus.wb_data_o, m_wbv, m_wbdst, m_wbdata);
            end
        end
    endtask

    initial begin
        rst_l = 1'b0;
        model_reset();
        $display("[TB] starting ovi_sb_tracker bench");
        test_reset();
        test_issue_three();
        test_out_of_order_complete();
        test_kill_wins();
        test_cmpl_to_free();
        test_fill_overflow();
        test_wrap();
        test_reset_midflight();
        test_random(1'b1, 1500);
        test_random(1'b0, 1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovi_sb_tracker.md
OVI_SB_TRACKER -- requirements
Module: ovi_sb_tracker

Interface
REQ-001 SHALL have parameter NUM_SB, default 8, meaning outstanding vector-instruction entries; power of 2, range 2..32.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the dest_reg/writeback data width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_l  in  1  asynchronous active-low reset.
REQ-006 iss_valid_i  in  1  core issues a vector instruction this cycle.
REQ-007 iss_wb_i  in  1  instruction writes a scalar result.
REQ-008 iss_dst_i  in  5  scalar destination register.
REQ-009 iss_ready_o  out  1  a free entry exists.
REQ-010 iss_sb_id_o  out  5  sb_id allocated to the current issue; zero-extended above clog2(NUM_SB).
REQ-011 commit_i  in  1  oldest undispatched entry becomes senior.
REQ-012 kill_i  in  1  oldest undispatched entry is squashed.
REQ-013 disp_sb_id_o  out  5  dispatch sb_id.
REQ-014 disp_next_senior_o  out  1  next_senior pulse.
REQ-015 disp_kill_o  out  1  kill pulse.
REQ-016 cmpl_valid_i  in  1  VPU completion.
REQ-017 cmpl_sb_id_i  in  5  completing sb_id.
REQ-018 cmpl_dest_reg_i  in  DATA_W  scalar result.
REQ-019 wb_valid_o  out  1  core writeback valid.
REQ-020 wb_dst_o  out  5  writeback register.
REQ-021 wb_data_o  out  DATA_W  writeback data.
REQ-022 count_o  out  clog2(NUM_SB+1)  occupied entries.
REQ-023 err_o  out  1  sticky protocol error.

Function
REQ-024 SHALL keep a ring of NUM_SB entries, each with state FREE, ISSUED, DISPATCHED or DONE, plus wb flag and dst; entry index = sb_id.
REQ-025 SHALL drive iss_ready_o = (count < NUM_SB) from registered state only; same-cycle retirement SHALL NOT be bypassed to issue.
REQ-026 On iss_valid_i && iss_ready_o: entry[tail] FREE->ISSUED; iss_sb_id_o = tail combinationally; tail increments and wraps from NUM_SB-1 to 0.
REQ-027 iss_valid_i while !iss_ready_o SHALL be dropped and SHALL set err_o.
REQ-028 On commit_i with entry[disp] ISSUED: entry->DISPATCHED; next cycle disp_next_senior_o=1 and disp_sb_id_o=disp; disp pointer advances.
REQ-029 On kill_i with entry[disp] ISSUED: entry->DONE with no writeback; next cycle disp_kill_o=1 and disp_sb_id_o=disp; disp pointer advances.
REQ-030 commit_i and kill_i asserted together: kill wins and commit is discarded.
REQ-031 commit_i or kill_i with no ISSUED entry at disp: ignored and err_o set.
REQ-032 On cmpl_valid_i with the addressed entry DISPATCHED: entry->DONE; if its wb flag is set, next cycle wb_valid_o=1 with its dst and cmpl_dest_reg_i; otherwise no writeback.
REQ-033 Completion to a non-DISPATCHED entry: ignored and err_o set.
REQ-034 Completions may arrive out of order.
REQ-035 Retirement: if entry[head] is DONE, it becomes FREE and head advances; at most one per cycle, in order.
REQ-036 count_o SHALL be +1 on issue, -1 on retire, and unchanged when both occur in the same cycle.
REQ-037 All pulse outputs SHALL be single-cycle registered.
REQ-038 Completion and retirement of the same entry in the same cycle SHALL NOT occur; DONE retires the following cycle.

Reset
REQ-039 rst_l low SHALL immediately force all entries FREE, head/tail/disp to 0, count_o 0, and err_o, wb_valid_o, disp_* and wb_* to 0.
REQ-040 Reset mid-operation SHALL discard in-flight entries with no pulses emitted.

Structure
REQ-041 Package ovi_pkg SHALL hold the sb_state_e enum, OVI_SBID_WIDTH=5 and the entry struct typedef.
REQ-042 One sub-module ovi_wrap_ctr (parametrised modulo-NUM_SB pointer counter) SHALL be instantiated for head, tail and disp.

Verification
REQ-043 Reset then issue 3 (wb=1, dst 5,6,7) -> sb_ids 0,1,2 and count_o=3.
REQ-044 Fill NUM_SB=8 -> iss_ready_o=0; a 9th iss_valid_i sets err_o and count_o stays 8.
REQ-045 Commit ids 0,1,2, then complete in order 2,0,1 with data A,B,C -> wb order dst7/A, dst5/B, dst6/C; retire in order 0,1,2 and count_o=0.
REQ-046 Commit and kill in the same cycle on id 0 -> disp_kill_o=1, sb_id 0, no next_senior, no wb; entry retires.
REQ-047 Issue 10 with NUM_SB=8, retiring as they go -> tail wraps and ids 8,9 map to 0,1.
REQ-048 Completion to a FREE id 4 -> err_o=1 and no wb_valid_o.
